// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the stall/flush/forwarding controller.
// The datapath side (master) drives the hazard inputs; the controller side (slave) drives the
// register enables, bubble controls, forwarding selects, the stall counter and the FSM debug view.
// Handshake: none; every signal is level-sensitive and sampled in the same cycle it is driven.
interface pipeline_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_uses_rt;
   logic [4:0]       ex_rs;
   logic [4:0]       ex_rt;
   logic             ex_mem_read;
   logic             ex_is_mul;
   logic             ex_branch_taken;
   logic             exmem_reg_write;
   logic [4:0]       exmem_rd;
   logic             memwb_reg_write;
   logic [4:0]       memwb_rd;
   logic             mem_req;
   logic             mem_ready;

   logic             pc_en;
   logic             ifid_en;
   logic             idex_en;
   logic             exmem_en;
   logic             memwb_en;
   logic             ifid_flush;
   logic             idex_flush;
   logic             exmem_flush;
   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;
   logic [CNT_W-1:0] stall_count;
   logic             dbg_state;
   logic [3:0]       dbg_cnt;

   modport master (
      output id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_mem_read, ex_is_mul,
             ex_branch_taken, exmem_reg_write, exmem_rd, memwb_reg_write, memwb_rd,
             mem_req, mem_ready,
      input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
             exmem_flush, fwd_a, fwd_b, stall_count, dbg_state, dbg_cnt
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_mem_read, ex_is_mul,
             ex_branch_taken, exmem_reg_write, exmem_rd, memwb_reg_write, memwb_rd,
             mem_req, mem_ready,
      output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
             exmem_flush, fwd_a, fwd_b, stall_count, dbg_state, dbg_cnt
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipeline.
// Priority each cycle: memory freeze > multiply occupancy > taken branch > load-use.
// A multiply holds EX for MUL_LATENCY cycles: MUL_LATENCY-1 stall cycles, then it advances.
// dbg_state (0 = RUN, 1 = MUL_BUSY) and dbg_cnt expose the FSM.
module pipeline_hazard_ctrl #(
   parameter int MUL_LATENCY = 4,
   parameter int CNT_W       = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   pipeline_hazard_ctrl_if.slave  hz
);

   typedef enum logic {RUN = 1'b0, MUL_BUSY = 1'b1} state_t;

   localparam logic [3:0] MUL_INIT = 4'(MUL_LATENCY - 2);

   state_t           state, state_nxt;
   logic [3:0]       cnt, cnt_nxt;
   logic [CNT_W-1:0] stall_count_q;
   logic             freeze;
   logic             load_use;

   assign freeze   = hz.mem_req & ~hz.mem_ready;
   assign load_use = hz.ex_mem_read && (hz.ex_rt != 5'd0) &&
                     ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));

   // State and multiply countdown register; reset returns to RUN at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= RUN;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state and enable/bubble outputs by priority; everything holds under freeze.
   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      hz.pc_en       = 1'b1;
      hz.ifid_en     = 1'b1;
      hz.idex_en     = 1'b1;
      hz.exmem_en    = 1'b1;
      hz.memwb_en    = 1'b1;
      hz.ifid_flush  = 1'b0;
      hz.idex_flush  = 1'b0;
      hz.exmem_flush = 1'b0;
      if (!reset || freeze) begin
         hz.pc_en    = 1'b0;
         hz.ifid_en  = 1'b0;
         hz.idex_en  = 1'b0;
         hz.exmem_en = 1'b0;
         hz.memwb_en = 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (hz.ex_is_mul) begin
                  hz.pc_en       = 1'b0;
                  hz.ifid_en     = 1'b0;
                  hz.idex_en     = 1'b0;
                  hz.exmem_flush = 1'b1;
                  state_nxt      = MUL_BUSY;
                  cnt_nxt        = MUL_INIT;
               end else if (hz.ex_branch_taken) begin
                  hz.ifid_flush = 1'b1;
                  hz.idex_flush = 1'b1;
               end else if (load_use) begin
                  hz.pc_en      = 1'b0;
                  hz.ifid_en    = 1'b0;
                  hz.idex_flush = 1'b1;
               end
            end
            MUL_BUSY: begin
               if (cnt != 4'd0) begin
                  hz.pc_en       = 1'b0;
                  hz.ifid_en     = 1'b0;
                  hz.idex_en     = 1'b0;
                  hz.exmem_flush = 1'b1;
                  cnt_nxt        = cnt - 4'd1;
               end else begin
                  // Multiply leaves EX this cycle; ex_is_mul still reflects it, so ignore it.
                  state_nxt = RUN;
               end
            end
            default: begin
               state_nxt = RUN;
               cnt_nxt   = 4'd0;
            end
         endcase
      end
   end

   // EX operand forwarding; the younger EX/MEM result wins and r0 is never forwarded.
   always_comb begin
      hz.fwd_a = 2'b00;
      hz.fwd_b = 2'b00;
      if (reset) begin
         if (hz.exmem_reg_write && (hz.exmem_rd != 5'd0) && (hz.exmem_rd == hz.ex_rs))
            hz.fwd_a = 2'b10;
         else if (hz.memwb_reg_write && (hz.memwb_rd != 5'd0) && (hz.memwb_rd == hz.ex_rs))
            hz.fwd_a = 2'b01;
         if (hz.exmem_reg_write && (hz.exmem_rd != 5'd0) && (hz.exmem_rd == hz.ex_rt))
            hz.fwd_b = 2'b10;
         else if (hz.memwb_reg_write && (hz.memwb_rd != 5'd0) && (hz.memwb_rd == hz.ex_rt))
            hz.fwd_b = 2'b01;
      end
   end

   // Saturating count of cycles in which the PC is held.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         stall_count_q <= '0;
      else if (!hz.pc_en && (stall_count_q != {CNT_W{1'b1}}))
         stall_count_q <= stall_count_q + CNT_W'(1);
   end

   assign hz.stall_count = stall_count_q;
   assign hz.dbg_state   = state;
   assign hz.dbg_cnt     = cnt;

endmodule
